// File: rtl/stack_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_PUSH,
    OP_POP,
    OP_REPL,
    OP_CLR
  } stack_op_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // CLR outranks the strobes; both strobes together mean replace-top
  function automatic stack_op_e decode_op(input logic ce, input logic clr,
                                          input logic push, input logic pop);
    if (!ce)  return OP_NOP;
    if (clr)  return OP_CLR;
    case ({push, pop})
      2'b10:   return OP_PUSH;
      2'b01:   return OP_POP;
      2'b11:   return OP_REPL;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/lifo_stack_p_if.sv
// Control/data bundle between the processor core and its LIFO stack.
interface lifo_stack_p_if
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int CNT_W     = cnt_width(DEPTH)
);
  logic                  CE;
  logic                  CLR;
  logic                  PUSH;
  logic                  POP;
  logic [DATA_WIDTH-1:0] DATA_IN;
  logic [DATA_WIDTH-1:0] TOP;
  logic [CNT_W-1:0]      COUNT;
  logic                  FULL;
  logic                  EMPTY;
  logic                  OVF;
  logic                  UNF;

  modport master (
    output CE, CLR, PUSH, POP, DATA_IN,
    input  TOP, COUNT, FULL, EMPTY, OVF, UNF
  );

  modport slave (
    input  CE, CLR, PUSH, POP, DATA_IN,
    output TOP, COUNT, FULL, EMPTY, OVF, UNF
  );
endinterface

// File: rtl/stack_regfile.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
module stack_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  WE,
  input  logic [AW-1:0]         WADDR,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [AW-1:0]         RADDR,
  output logic [DATA_WIDTH-1:0] RDATA
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset
  always_ff @(posedge CLK) begin
    if (WE) mem[WADDR] <= WDATA;
  end

  assign RDATA = mem[RADDR];

endmodule

// File: rtl/lifo_stack_p.sv
// Parametrised LIFO data/return stack with push, pop, replace-top and clear.
// Define LIFO_STACK_ERR_EN to build the sticky OVF/UNF error flops.
module lifo_stack_p
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int CNT_W     = cnt_width(DEPTH),
  localparam int AW        = $clog2(DEPTH)
) (
  input logic           CLK,
  input logic           nRST,
  lifo_stack_p_if.slave bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  stack_op_e             op;
  logic [CNT_W-1:0]      sp;
  logic [CNT_W-1:0]      sp_next;
  logic                  full;
  logic                  empty;
  logic                  we;
  logic [AW-1:0]         waddr;
  logic [AW-1:0]         raddr;
  logic [DATA_WIDTH-1:0] rdata;

  assign op    = decode_op(bus.CE, bus.CLR, bus.PUSH, bus.POP);
  assign full  = (sp == DEPTH_C);
  assign empty = (sp == '0);

  always_comb begin
    sp_next = sp;
    case (op)
      OP_CLR:  sp_next = '0;
      OP_PUSH: if (!full)  sp_next = sp + ONE_C;
      OP_POP:  if (!empty) sp_next = sp - ONE_C;
      OP_REPL: if (empty)  sp_next = ONE_C;
      default: sp_next = sp;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) sp <= '0;
    else       sp <= sp_next;
  end

  // Gating with nRST keeps an edge that coincides with reset from writing
  always_comb begin
    we    = 1'b0;
    waddr = AW'(sp);
    case (op)
      OP_PUSH: we = nRST && !full;
      OP_REPL: begin
        we    = nRST;
        waddr = empty ? AW'(sp) : AW'(sp - ONE_C);
      end
      default: we = 1'b0;
    endcase
  end

  assign raddr = empty ? '0 : AW'(sp - ONE_C);

  stack_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_regfile (
    .CLK   (CLK),
    .WE    (we),
    .WADDR (waddr),
    .WDATA (bus.DATA_IN),
    .RADDR (raddr),
    .RDATA (rdata)
  );

  assign bus.TOP   = empty ? '0 : rdata;
  assign bus.COUNT = sp;
  assign bus.FULL  = full;
  assign bus.EMPTY = empty;

`ifdef LIFO_STACK_ERR_EN
  logic ovf;
  logic unf;

  // Sticky error flags; only reset or CLR clears them
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      case (op)
        OP_CLR: begin
          ovf <= 1'b0;
          unf <= 1'b0;
        end
        OP_PUSH: if (full)  ovf <= 1'b1;
        OP_POP:  if (empty) unf <= 1'b1;
        OP_REPL: if (empty) unf <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.OVF = ovf;
  assign bus.UNF = unf;
`else
  assign bus.OVF = 1'b0;
  assign bus.UNF = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack_p.sv
// Scoreboard bench for lifo_stack_p (DATA_WIDTH=8, DEPTH=4); flag expectations follow LIFO_STACK_ERR_EN.
module tb_lifo_stack_p;

`ifdef LIFO_STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [2:0] count;
    logic [7:0] top;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic CLK;
  logic nRST;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t scoreboard[$];

  lifo_stack_p_if #(.DATA_WIDTH(8), .DEPTH(4)) bus ();

  lifo_stack_p #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input exp_t e);
    compared++;
    if (bus.COUNT !== e.count || bus.TOP !== e.top || bus.FULL !== e.full ||
        bus.EMPTY !== e.empty || bus.OVF !== e.ovf || bus.UNF !== e.unf) begin
      mismatched++;
      $display("[TB] FAIL %s: actual cnt=%0d top=%h f=%b e=%b ovf=%b unf=%b required cnt=%0d top=%h f=%b e=%b ovf=%b unf=%b",
               e.name, bus.COUNT, bus.TOP, bus.FULL, bus.EMPTY, bus.OVF, bus.UNF,
               e.count, e.top, e.full, e.empty, e.ovf, e.unf);
    end
  endtask

  // Monitor: each negedge, compare the oldest expectation issued before the last posedge
  initial begin
    forever begin
      @(negedge CLK);
      if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
    end
  end

  task automatic applyStimulus(input string name, input logic ce, input logic clr,
                               input logic push, input logic pop, input logic [7:0] din,
                               input int ecount, input logic [7:0] etop,
                               input logic eovf, input logic eunf);
    exp_t e;
    @(negedge CLK);
    #1;
    bus.CE      = ce;
    bus.CLR     = clr;
    bus.PUSH    = push;
    bus.POP     = pop;
    bus.DATA_IN = din;
    e.name  = name;
    e.count = 3'(ecount);
    e.top   = etop;
    e.full  = (ecount == 4);
    e.empty = (ecount == 0);
    e.ovf   = eovf & ERR;
    e.unf   = eunf & ERR;
    scoreboard.push_back(e);
  endtask

  initial begin
    exp_t rst_e;
    int   budget;
    nRST        = 1'b0;
    bus.CE      = 1'b0;
    bus.CLR     = 1'b0;
    bus.PUSH    = 1'b0;
    bus.POP     = 1'b0;
    bus.DATA_IN = 8'h00;
    repeat (2) @(negedge CLK);
    #1 nRST = 1'b1;

    applyStimulus("idle",    1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);
    applyStimulus("push11a", 1, 0, 1, 0, 8'h11, 1, 8'h11, 0, 0);

    // Asynchronous reset in the middle of a push, checked before the next edge
    @(negedge CLK);
    #1;
    bus.PUSH    = 1'b1;
    bus.DATA_IN = 8'h99;
    #2 nRST = 1'b0;
    #1;
    rst_e = '{name: "async_rst", count: 3'd0, top: 8'h00, full: 1'b0,
              empty: 1'b1, ovf: 1'b0, unf: 1'b0};
    checkOutput(rst_e);
    @(negedge CLK);
    #1;
    bus.PUSH = 1'b0;
    nRST     = 1'b1;
    applyStimulus("post_rst", 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    applyStimulus("push11",  1, 0, 1, 0, 8'h11, 1, 8'h11, 0, 0);
    applyStimulus("push22",  1, 0, 1, 0, 8'h22, 2, 8'h22, 0, 0);
    applyStimulus("push33",  1, 0, 1, 0, 8'h33, 3, 8'h33, 0, 0);
    applyStimulus("push44",  1, 0, 1, 0, 8'h44, 4, 8'h44, 0, 0);
    applyStimulus("ovf55",   1, 0, 1, 0, 8'h55, 4, 8'h44, 1, 0);
    applyStimulus("pop1",    1, 0, 0, 1, 8'h00, 3, 8'h33, 1, 0);
    applyStimulus("pop2",    1, 0, 0, 1, 8'h00, 2, 8'h22, 1, 0);
    applyStimulus("pop3",    1, 0, 0, 1, 8'h00, 1, 8'h11, 1, 0);
    applyStimulus("pop4",    1, 0, 0, 1, 8'h00, 0, 8'h00, 1, 0);
    applyStimulus("unf_pop", 1, 0, 0, 1, 8'h00, 0, 8'h00, 1, 1);
    applyStimulus("clr1",    1, 1, 1, 1, 8'hEE, 0, 8'h00, 0, 0);

    applyStimulus("pushA0",  1, 0, 1, 0, 8'hA0, 1, 8'hA0, 0, 0);
    applyStimulus("replB0",  1, 0, 1, 1, 8'hB0, 1, 8'hB0, 0, 0);
    applyStimulus("pushC1",  1, 0, 1, 0, 8'hC1, 2, 8'hC1, 0, 0);
    applyStimulus("pushC2",  1, 0, 1, 0, 8'hC2, 3, 8'hC2, 0, 0);
    applyStimulus("pushC3",  1, 0, 1, 0, 8'hC3, 4, 8'hC3, 0, 0);
    applyStimulus("replCC",  1, 0, 1, 1, 8'hCC, 4, 8'hCC, 0, 0);
    applyStimulus("popCC",   1, 0, 0, 1, 8'h00, 3, 8'hC2, 0, 0);
    applyStimulus("clr2",    1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0);

    applyStimulus("repl_empty", 1, 0, 1, 1, 8'h5A, 1, 8'h5A, 0, 1);

    applyStimulus("ce0_push", 0, 0, 1, 0, 8'h77, 1, 8'h5A, 0, 1);
    applyStimulus("ce0_pop",  0, 0, 0, 1, 8'h78, 1, 8'h5A, 0, 1);
    applyStimulus("ce0_clr",  0, 1, 0, 0, 8'h79, 1, 8'h5A, 0, 1);
    applyStimulus("ce0_repl", 0, 0, 1, 1, 8'h7A, 1, 8'h5A, 0, 1);
    applyStimulus("ce0_all",  0, 1, 1, 1, 8'h7B, 1, 8'h5A, 0, 1);
    applyStimulus("pop_last", 1, 0, 0, 1, 8'h00, 0, 8'h00, 0, 1);
    applyStimulus("idle_end", 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1);

    budget = 0;
    while (scoreboard.size() > 0 && budget < 20) begin
      @(negedge CLK);
      budget++;
    end
    #1;
    if (scoreboard.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: actual pending=%0d required pending=0", scoreboard.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
